// File: rtl/multichannel_reciprocal_counter_if.sv
// Wishbone slave bundle for the multichannel reciprocal counter.
interface multichannel_reciprocal_counter_if;
  logic [31:0] addr_i;
  logic [31:0] dat_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output addr_i, dat_i, we_i, sel_i, cyc_i, stb_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  addr_i, dat_i, we_i, sel_i, cyc_i, stb_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/multichannel_reciprocal_counter.sv
// Reciprocal frequency counter: per channel, counts clk_i cycles over a programmable
// number of input periods. Inputs are synchronised into clk_i; Wishbone register access.
module multichannel_reciprocal_counter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int EDGE_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TARGET_RST  = 1000
) (
  input  logic                            clk_i,
  input  logic                            ext_rst_i,
  multichannel_reciprocal_counter_if.slave bus,
  input  logic [NUM_CH-1:0]               signal_input,
  output logic                            irq_o,
  output logic [NUM_CH-1:0]               busy_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_COUNT, ST_DONE, ST_TOUT} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_p0;
  logic [NUM_CH-1:0]                  lvl_p1;
  logic [NUM_CH-1:0]                  edge_p1;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  ref_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  wd_q [NUM_CH];
  logic [EDGE_W-1:0] ecnt_q [NUM_CH];
  logic [EDGE_W-1:0] tgt_q [NUM_CH];
  logic [CNT_W-1:0]  result_q [NUM_CH];

  logic [NUM_CH-1:0] done_q, tout_q, irq_en_q;
  logic [EDGE_W-1:0] target_q;
  logic [CNT_W-1:0]  timeout_q;

  logic              req, wr, abort, mapped;
  logic              hit_ctrl, hit_status, hit_target, hit_timeout, hit_res;
  logic [NUM_CH-1:0] start_req, clr_done, clr_tout;
  logic [NUM_CH-1:0] load_start, go_count, final_edge, set_done, set_tout, wd_exp;
  logic [31:0]       rdata;

  // Input stage p0: synchroniser chain; p1: registered rise detect
  always_ff @(posedge clk_i) begin
    if (!ext_rst_i) begin
      sync_p0 <= '0;
      lvl_p1  <= '0;
      edge_p1 <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_p0[ch] <= {sync_p0[ch][SYNC_STAGES-2:0], signal_input[ch]};
        lvl_p1[ch]  <= sync_p0[ch][SYNC_STAGES-1];
        edge_p1[ch] <= sync_p0[ch][SYNC_STAGES-1] & ~lvl_p1[ch];
      end
    end
  end

  always_comb begin
    req         = bus.cyc_i & bus.stb_i & ~bus.ack_o & ~bus.err_o;
    wr          = req & bus.we_i;
    hit_ctrl    = (bus.addr_i == 32'h0);
    hit_status  = (bus.addr_i == 32'h1);
    hit_target  = (bus.addr_i == 32'h2);
    hit_timeout = (bus.addr_i == 32'h3);
    hit_res     = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++)
      if (bus.addr_i == 32'h10 + 32'(ch)) hit_res = 1'b1;
    mapped    = hit_ctrl | hit_status | hit_target | hit_timeout | hit_res;
    abort     = wr & hit_ctrl & bus.sel_i[3] & bus.dat_i[31];
    start_req = (wr & hit_ctrl & bus.sel_i[0]) ? bus.dat_i[NUM_CH-1:0] : '0;
    clr_done  = (wr & hit_status & bus.sel_i[0]) ? bus.dat_i[NUM_CH-1:0] : '0;
    clr_tout  = (wr & hit_status & bus.sel_i[1]) ? bus.dat_i[8 +: NUM_CH] : '0;
  end

  always_comb begin
    rdata = '0;
    if (hit_ctrl)
      rdata[15:8] = 8'(irq_en_q);
    else if (hit_status)
      rdata[23:0] = {8'(busy_o), 8'(tout_q), 8'(done_q)};
    else if (hit_target)
      rdata = 32'(target_q);
    else if (hit_timeout)
      rdata = 32'(timeout_q);
    else
      for (int ch = 0; ch < NUM_CH; ch++)
        if (bus.addr_i == 32'h10 + 32'(ch)) rdata = 32'(result_q[ch]);
  end

  // Abort outranks the watchdog, which outranks a coincident final edge
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_d[ch]    = state_q[ch];
      load_start[ch] = 1'b0;
      go_count[ch]   = 1'b0;
      final_edge[ch] = 1'b0;
      set_done[ch]   = 1'b0;
      set_tout[ch]   = 1'b0;
      wd_exp[ch]     = (timeout_q != '0) && (wd_q[ch] == timeout_q - CNT_ONE);
      case (state_q[ch])
        ST_IDLE: begin
          if (start_req[ch] && !abort) begin
            state_d[ch]    = ST_ARM;
            load_start[ch] = 1'b1;
          end
        end
        ST_ARM: begin
          if (abort)
            state_d[ch] = ST_IDLE;
          else if (wd_exp[ch])
            state_d[ch] = ST_TOUT;
          else if (edge_p1[ch]) begin
            state_d[ch]  = ST_COUNT;
            go_count[ch] = 1'b1;
          end
        end
        ST_COUNT: begin
          if (abort)
            state_d[ch] = ST_IDLE;
          else if (wd_exp[ch])
            state_d[ch] = ST_TOUT;
          else if (edge_p1[ch] && (ecnt_q[ch] + EDGE_ONE == tgt_q[ch])) begin
            state_d[ch]    = ST_DONE;
            final_edge[ch] = 1'b1;
          end
        end
        ST_DONE: begin
          state_d[ch]  = ST_IDLE;
          set_done[ch] = ~abort;
        end
        ST_TOUT: begin
          state_d[ch]  = ST_IDLE;
          set_tout[ch] = ~abort;
        end
        default: state_d[ch] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!ext_rst_i) state_q[ch] <= ST_IDLE;
      else            state_q[ch] <= state_d[ch];
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++)
      busy_o[ch] = (state_q[ch] != ST_IDLE);
  end

  // Measurement datapath; every field is loaded before it is consulted
  always_ff @(posedge clk_i) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (load_start[ch]) begin
        tgt_q[ch] <= (target_q == '0) ? EDGE_ONE : target_q;
        wd_q[ch]  <= '0;
      end else if (state_q[ch] == ST_ARM || state_q[ch] == ST_COUNT) begin
        wd_q[ch] <= sat_inc(wd_q[ch]);
      end
      if (go_count[ch]) begin
        ref_cnt_q[ch] <= CNT_ONE;
        ecnt_q[ch]    <= '0;
      end else if (state_q[ch] == ST_COUNT) begin
        ref_cnt_q[ch] <= sat_inc(ref_cnt_q[ch]);
        if (edge_p1[ch]) ecnt_q[ch] <= ecnt_q[ch] + EDGE_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!ext_rst_i) begin
      done_q    <= '0;
      tout_q    <= '0;
      irq_en_q  <= '0;
      target_q  <= EDGE_W'(TARGET_RST);
      timeout_q <= '0;
      irq_o     <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) result_q[ch] <= '0;
    end else begin
      done_q <= set_done | (done_q & ~(clr_done | load_start));
      tout_q <= set_tout | (tout_q & ~(clr_tout | load_start));
      if (wr & hit_ctrl & bus.sel_i[1]) irq_en_q <= bus.dat_i[8 +: NUM_CH];
      if (wr & hit_target)
        target_q <= EDGE_W'(byte_merge(32'(target_q), bus.dat_i, bus.sel_i));
      if (wr & hit_timeout)
        timeout_q <= CNT_W'(byte_merge(32'(timeout_q), bus.dat_i, bus.sel_i));
      irq_o <= |((done_q | tout_q) & irq_en_q);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (final_edge[ch])    result_q[ch] <= ref_cnt_q[ch];
        else if (set_tout[ch]) result_q[ch] <= '0;
      end
    end
  end

  // Bus response stage: one registered ack/err per accepted request
  always_ff @(posedge clk_i) begin
    if (!ext_rst_i) begin
      bus.ack_o <= 1'b0;
      bus.err_o <= 1'b0;
      bus.dat_o <= '0;
    end else begin
      bus.ack_o <= req & mapped;
      bus.err_o <= req & ~mapped;
      bus.dat_o <= (req & mapped & ~bus.we_i) ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_multichannel_reciprocal_counter.sv
// Bench for multichannel_reciprocal_counter: register reads are scored against
// expectations queued when each read is issued; inputs are clk-aligned square waves.
module tb_multichannel_reciprocal_counter;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              ext_rst = 1'b0;
  logic [NUM_CH-1:0] sig = '0;
  logic              irq;
  logic [NUM_CH-1:0] busy;
  int                checks = 0;
  int                failures = 0;
  int                per [NUM_CH] = '{default: 0};
  logic [31:0]       last_rd;
  logic              last_err;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t  sb_q [$];
  string tag_q [$];

  multichannel_reciprocal_counter_if bif();

  multichannel_reciprocal_counter #(
    .NUM_CH(NUM_CH), .CNT_W(32), .EDGE_W(16), .SYNC_STAGES(2), .TARGET_RST(1000)
  ) dut (
    .clk_i(clk),
    .ext_rst_i(ext_rst),
    .bus(bif),
    .signal_input(sig),
    .irq_o(irq),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Square waves: a rising edge exactly every per[c] clocks; per[c]==0 holds low
  initial begin
    int ph [NUM_CH];
    for (int c = 0; c < NUM_CH; c++) ph[c] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int c = 0; c < NUM_CH; c++) begin
        if (per[c] == 0) begin
          ph[c]  = 0;
          sig[c] = 1'b0;
        end else begin
          ph[c]  = (ph[c] + 1) % per[c];
          sig[c] = (ph[c] < per[c] / 2);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d,
                          input logic we, input logic [3:0] sel);
    int n = 0;
    @(posedge clk);
    #1;
    bif.addr_i = a;
    bif.dat_i  = d;
    bif.we_i   = we;
    bif.sel_i  = sel;
    bif.cyc_i  = 1'b1;
    bif.stb_i  = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(bif.ack_o || bif.err_o) && n < 20);
    last_rd  = bif.dat_o;
    last_err = bif.err_o;
    chk("bus_latency", 32'(n), 32'd1);
    bif.cyc_i = 1'b0;
    bif.stb_i = 1'b0;
    bif.we_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    bus_xfer(a, d, 1'b1, sel);
    chk("write_err", {31'b0, last_err}, 32'h0);
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic e);
    exp_t  x;
    string t;
    sb_q.push_back('{data: d, err: e});
    tag_q.push_back(tag);
    bus_xfer(a, 32'h0, 1'b0, 4'hF);
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_err"}, {31'b0, last_err}, {31'b0, x.err});
    chk(t, last_rd, x.data);
  endtask

  task automatic wait_idle(input string tag, input logic [NUM_CH-1:0] mask, input int limit);
    int n = 0;
    while (((busy & mask) != '0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(busy & mask), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bif.addr_i = '0;
    bif.dat_i  = '0;
    bif.we_i   = 1'b0;
    bif.sel_i  = '0;
    bif.cyc_i  = 1'b0;
    bif.stb_i  = 1'b0;

    ext_rst = 1'b0;
    cycles(4);
    chk("rst_ack", {31'b0, bif.ack_o}, 32'h0);
    chk("rst_err", {31'b0, bif.err_o}, 32'h0);
    chk("rst_dat", bif.dat_o, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    ext_rst = 1'b1;
    cycles(2);
    rd_exp("target_rst", 32'h2, 32'd1000, 1'b0);
    rd_exp("bad_addr", 32'h7, 32'h0, 1'b1);
    rd_exp("status_rst", 32'h1, 32'h0, 1'b0);
    rd_exp("timeout_rst", 32'h3, 32'h0, 1'b0);
    rd_exp("result0_rst", 32'h10, 32'h0, 1'b0);

    // single channel, period 10 over 4 periods, then period 7 over 1
    per[0] = 10;
    cycles(30);
    wr(32'h2, 32'd4, 4'hF);
    wr(32'h0, 32'h01, 4'hF);
    chk("busy0_start", {31'b0, busy[0]}, 32'h1);
    wait_idle("ch0_p10_idle", 4'b0001, 300);
    rd_exp("status_ch0", 32'h1, 32'h1, 1'b0);
    rd_exp("result0_p10", 32'h10, 32'd40, 1'b0);
    per[0] = 7;
    cycles(30);
    wr(32'h2, 32'd1, 4'hF);
    wr(32'h0, 32'h01, 4'hF);
    wait_idle("ch0_p7_idle", 4'b0001, 100);
    rd_exp("status_ch0_p7", 32'h1, 32'h1, 1'b0);
    rd_exp("result0_p7", 32'h10, 32'd7, 1'b0);

    // all channels together; done bits rise one at a time
    per = '{5, 6, 8, 13};
    cycles(30);
    wr(32'h2, 32'd100, 4'hF);
    wr(32'h0, 32'h0F, 4'hF);
    wait_idle("all_ch0_idle", 4'b0001, 1000);
    rd_exp("status_after_ch0", 32'h1, 32'h000E0001, 1'b0);
    wait_idle("all_ch1_idle", 4'b0010, 1000);
    rd_exp("status_after_ch1", 32'h1, 32'h000C0003, 1'b0);
    wait_idle("all_ch2_idle", 4'b0100, 1000);
    rd_exp("status_after_ch2", 32'h1, 32'h00080007, 1'b0);
    wait_idle("all_ch3_idle", 4'b1000, 1000);
    rd_exp("status_after_ch3", 32'h1, 32'h0000000F, 1'b0);
    rd_exp("result0_p5", 32'h10, 32'd500, 1'b0);
    rd_exp("result1_p6", 32'h11, 32'd600, 1'b0);
    rd_exp("result2_p8", 32'h12, 32'd800, 1'b0);
    rd_exp("result3_p13", 32'h13, 32'd1300, 1'b0);

    // watchdog on a silent channel, with interrupt and W1C
    wr(32'h1, 32'h0000FFFF, 4'hF);
    rd_exp("status_cleared", 32'h1, 32'h0, 1'b0);
    per[1] = 0;
    cycles(10);
    wr(32'h3, 32'd50, 4'hF);
    wr(32'h0, 32'h0202, 4'hF);
    chk("irq_before_tout", {31'b0, irq}, 32'h0);
    wait_idle("tout_ch1_idle", 4'b0010, 200);
    cycles(2);
    chk("irq_tout", {31'b0, irq}, 32'h1);
    rd_exp("status_tout", 32'h1, 32'h00000200, 1'b0);
    rd_exp("result1_tout", 32'h11, 32'h0, 1'b0);
    rd_exp("ctrl_irq_en", 32'h0, 32'h00000200, 1'b0);
    wr(32'h1, 32'h00000200, 4'hF);
    cycles(1);
    chk("irq_w1c", {31'b0, irq}, 32'h0);
    wr(32'h3, 32'h0, 4'hF);

    // abort beats a start in the same write
    per[2] = 8;
    cycles(30);
    wr(32'h0, 32'h04, 4'b0001);
    cycles(50);
    chk("busy2_running", {31'b0, busy[2]}, 32'h1);
    wr(32'h0, 32'h80000004, 4'hF);
    chk("busy2_abort", {31'b0, busy[2]}, 32'h0);
    cycles(3);
    chk("busy2_stays_idle", {31'b0, busy[2]}, 32'h0);
    rd_exp("status_abort", 32'h1, 32'h0, 1'b0);
    rd_exp("result2_abort", 32'h12, 32'd800, 1'b0);

    // start and TARGET write while busy leave the running measurement alone
    per[0] = 6;
    cycles(30);
    wr(32'h2, 32'd10, 4'hF);
    wr(32'h0, 32'h01, 4'b0001);
    cycles(20);
    wr(32'h0, 32'h01, 4'b0001);
    wr(32'h2, 32'd3, 4'hF);
    wait_idle("restart_idle", 4'b0001, 300);
    rd_exp("result0_restart", 32'h10, 32'd60, 1'b0);
    rd_exp("status_restart", 32'h1, 32'h1, 1'b0);
    cycles(5);
    chk("busy_after_restart", 32'(busy), 32'h0);
    rd_exp("target_readback", 32'h2, 32'd3, 1'b0);
    wr(32'h2, 32'h12345678, 4'b0001);
    rd_exp("target_byte_sel", 32'h2, 32'h78, 1'b0);

    // TARGET of zero measures a single period
    per[0] = 9;
    cycles(30);
    wr(32'h2, 32'h0, 4'hF);
    wr(32'h0, 32'h01, 4'b0001);
    wait_idle("target0_idle", 4'b0001, 100);
    rd_exp("result0_target0", 32'h10, 32'd9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multichannel_reciprocal_counter.md
Name: multichannel_reciprocal_counter

Overview:
- Parametrised successor to the single-channel frequency counter.
- Measures NUM_CH input signals in parallel. For each channel it counts clk_i reference cycles across a programmable number of input periods, so frequency = f_clk × target / result.
- Runs entirely in the clk_i domain: inputs are synchronised and edge-detected internally, with no input-clocked logic.
- Adds per-channel start, a timeout watchdog, an abort, W1C status and an interrupt. Sits as a Wishbone slave beside the existing counter.

Parameters:
- NUM_CH, 4, number of measured channels (1..8).
- CNT_W, 32, width of the reference-cycle counter and result (≤32).
- EDGE_W, 16, width of the period-target register and edge counter.
- SYNC_STAGES, 2, flip-flop synchroniser depth per input (≥2).
- TARGET_RST, 1000, reset value of the TARGET register.

Ports:
- clk_i  in  1  single system/reference clock.
- ext_rst_i  in  1  reset: one clock; reset is synchronous and active-low.
- addr_i  in  32  Wishbone word address.
- dat_i  in  32  write data.
- we_i  in  1  write enable.
- sel_i  in  4  byte selects; writes apply only to selected bytes.
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- signal_input  in  NUM_CH  asynchronous signals under measurement.
- dat_o  out  32  read data.
- ack_o  out  1  transfer acknowledge.
- err_o  out  1  bad-address acknowledge.
- irq_o  out  1  level interrupt.
- busy_o  out  NUM_CH  channel FSM is not IDLE.

Behaviour:
- Reset (ext_rst_i=0 at a clk_i edge):
  - dat_o, ack_o, err_o, irq_o and busy_o are 0.
  - All FSMs go to IDLE; flags, results and IRQ_EN are 0; TARGET=TARGET_RST; TIMEOUT=0.
- Register map (word addresses):
  - 0x0 CTRL: [7:0] start strobes (write-1, read 0); [15:8] IRQ_EN; [31] abort-all (self-clearing, reads 0).
  - 0x1 STATUS: [7:0] done, [15:8] timeout (both W1C), [23:16] busy (RO).
  - 0x2 TARGET: [EDGE_W-1:0]. A value of 0 is treated as 1.
  - 0x3 TIMEOUT: [CNT_W-1:0]. A value of 0 disables the watchdog.
  - 0x10+ch RESULT[ch]: RO, zero-extended.
  - Bits for ch ≥ NUM_CH read 0 and ignore writes.
- Bus handshake:
  - When cyc_i&stb_i&~ack_o&~err_o, the next cycle asserts exactly one of ack_o/err_o for one cycle, with dat_o valid alongside it.
  - Unmapped addresses assert err_o with dat_o=0 and no side effects.
  - Back-to-back accesses give one response every 2 cycles.
- Input path: SYNC_STAGES synchroniser, then a registered rise detect. An edge pulse appears SYNC_STAGES+1 cycles after the input rises. Start and end edges share this latency, so it cancels.
- Per-channel FSM:
  - IDLE: a start bit goes to ARM. Clear that channel's done/timeout flags and load wd=0. Sample TARGET into tgt.
  - ARM: wait for an edge, then go to COUNT with ref=1, ecnt=0.
  - COUNT:
    - Each cycle, ref increments, saturating at all-ones.
    - Each edge increments ecnt. On the edge where ecnt+1==tgt, write RESULT=ref and go to DONE.
    - An edge and an increment in the same cycle use the pre-increment ref.
  - DONE (1 cycle): set the done flag, then go to IDLE.
  - TOUT (1 cycle): set the timeout flag, write RESULT=0, then go to IDLE.
- Watchdog: wd increments every cycle in ARM/COUNT. If TIMEOUT≠0 and wd==TIMEOUT-1, go to TOUT. A timeout takes priority over a coincident final edge.
- Start while busy is ignored. TARGET writes mid-measurement do not affect that measurement.
- Abort-all: every non-IDLE FSM goes to IDLE the next cycle. No flags are set and RESULT is unchanged. Abort beats a start in the same write.
- Flag set and W1C clear in the same cycle: set wins.
- irq_o is registered: irq_o = |((done|timeout) & IRQ_EN), one cycle after the flag.
- busy_o[ch] = (state≠IDLE), driven from registered state.

Test Plan:
- Reset with the bus idle → all outputs 0; read 0x2 returns 1000 with ack_o one cycle after stb; read 0x7 gives err_o=1, dat_o=0.
- ch0 at period 10 clk, TARGET=4, write CTRL=0x01 → busy_o[0]=1, then done[0]=1 and RESULT[0]=40. Repeat with period 7, TARGET=1 → RESULT=7.
- All 4 channels at periods 5/6/8/13, TARGET=100, single CTRL=0x0F → RESULTs 500/600/800/1300; each done bit rises independently.
- ch1 input held low, TIMEOUT=50, IRQ_EN=0x200 → timeout[1]=1 and RESULT[1]=0. irq_o goes to 1; W1C 0x200 to STATUS → irq_o=0 next cycle.
- ch2 running, CTRL=0x80000004 (abort and start) → busy_o[2]=0 next cycle, no flags set, RESULT[2] unchanged.
- Start ch0 while ch0 is busy and write TARGET mid-run → the original measurement completes with the original target; the repeated start has no effect.
